// File: rtl/layer1_backward.sv
// ---------------------------------------------------------------------------
// layer1_backward
//
// Backward pass of the first dense layer (2x2 weights, per-neuron bias,
// leaky ReLU). All datapath values are signed Q8.8 in 16 bits.
//
// For each streamed sample it:
//   stage p0: applies the leaky-ReLU derivative to the upstream gradients
//             and produces delta_1/delta_2
//   stage p1: propagates delta back through the weights (grad_in_1/2) and
//             accumulates the weight and bias gradients
// After the batch's last sample drains, one SGD step updates all six
// parameters, and update_valid pulses for one cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a batch (IDLE only)
//   in_valid, in_last        sample strobe / last-sample flag (ACCUM only)
//   grad_1/2, preact_1/2     upstream gradient and forward pre-activation
//   x_1/2                    forward layer inputs
//   weight_*, bias_*         current parameters, stable for the whole batch
//   leak_factor              leaky-ReLU negative slope
//   learning_rate            SGD step size
//   busy                     high in every state but IDLE
//   delta_valid, delta_1/2   local gradients after the activation derivative
//   grad_valid, grad_in_1/2  dL/dx for the previous layer
//   update_valid             one-cycle pulse with the new parameters
//   *_new                    updated parameters, held until the next update
// ---------------------------------------------------------------------------
module layer1_backward (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic signed [15:0] grad_1,
  input  logic signed [15:0] grad_2,
  input  logic signed [15:0] preact_1,
  input  logic signed [15:0] preact_2,
  input  logic signed [15:0] x_1,
  input  logic signed [15:0] x_2,
  input  logic signed [15:0] weight_11,
  input  logic signed [15:0] weight_12,
  input  logic signed [15:0] weight_21,
  input  logic signed [15:0] weight_22,
  input  logic signed [15:0] bias_1,
  input  logic signed [15:0] bias_2,
  input  logic signed [15:0] leak_factor,
  input  logic signed [15:0] learning_rate,
  output logic               busy,
  output logic               delta_valid,
  output logic signed [15:0] delta_1,
  output logic signed [15:0] delta_2,
  output logic               grad_valid,
  output logic signed [15:0] grad_in_1,
  output logic signed [15:0] grad_in_2,
  output logic               update_valid,
  output logic signed [15:0] weight_11_new,
  output logic signed [15:0] weight_12_new,
  output logic signed [15:0] weight_21_new,
  output logic signed [15:0] weight_22_new,
  output logic signed [15:0] bias_1_new,
  output logic signed [15:0] bias_2_new
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, UPDATE} state_t;

  state_t state;

  // Clamp a 32-bit intermediate into the 16-bit signed range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [31:0] sext(input logic signed [DATA_W-1:0] a);
    return {{16{a[DATA_W-1]}}, a};
  endfunction

  // Q8.8 multiply: exact 32-bit product, floor shift by 8, then saturate.
  function automatic logic signed [DATA_W-1:0] mul_q(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [31:0] p;
    p = sext(a) * sext(b);
    return sat16(p >>> 8);
  endfunction

  function automatic logic signed [DATA_W-1:0] add_sat(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    return sat16(sext(a) + sext(b));
  endfunction

  function automatic logic signed [DATA_W-1:0] sub_sat(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    return sat16(sext(a) - sext(b));
  endfunction

  logic                     accept;
  logic signed [DATA_W-1:0] delta_1_c, delta_2_c;

  logic                     vld_p0, vld_p1;
  logic signed [DATA_W-1:0] delta_1_p0, delta_2_p0;
  logic signed [DATA_W-1:0] grad_in_1_p1, grad_in_2_p1;

  logic signed [DATA_W-1:0] acc_w11, acc_w12, acc_w21, acc_w22;
  logic signed [DATA_W-1:0] acc_b1, acc_b2;

  assign accept = in_valid && (state == ACCUM);

  // Zero pre-activation takes the leak path.
  always_comb begin
    delta_1_c = grad_1;
    delta_2_c = grad_2;
    if (preact_1 <= 16'sd0) delta_1_c = mul_q(grad_1, leak_factor);
    if (preact_2 <= 16'sd0) delta_2_c = mul_q(grad_2, leak_factor);
  end

  // ---- stage p0: activation derivative ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      delta_1_p0 <= '0;
      delta_2_p0 <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        delta_1_p0 <= delta_1_c;
        delta_2_p0 <= delta_2_c;
      end
    end
  end

  // ---- stage p1: propagation and gradient accumulation ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      grad_in_1_p1 <= '0;
      grad_in_2_p1 <= '0;
      acc_w11      <= '0;
      acc_w12      <= '0;
      acc_w21      <= '0;
      acc_w22      <= '0;
      acc_b1       <= '0;
      acc_b2       <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        grad_in_1_p1 <= add_sat(mul_q(weight_11, delta_1_p0), mul_q(weight_12, delta_2_p0));
        grad_in_2_p1 <= add_sat(mul_q(weight_21, delta_1_p0), mul_q(weight_22, delta_2_p0));
      end
      // A batch start always wins; no sample is in flight while IDLE.
      if (state == IDLE && start) begin
        acc_w11 <= '0;
        acc_w12 <= '0;
        acc_w21 <= '0;
        acc_w22 <= '0;
        acc_b1  <= '0;
        acc_b2  <= '0;
      end else if (vld_p0) begin
        acc_w11 <= add_sat(acc_w11, mul_q(x_1_hold_1(), delta_1_p0));
        acc_w12 <= add_sat(acc_w12, mul_q(x_1_hold_1(), delta_2_p0));
        acc_w21 <= add_sat(acc_w21, mul_q(x_2_hold_1(), delta_1_p0));
        acc_w22 <= add_sat(acc_w22, mul_q(x_2_hold_1(), delta_2_p0));
        acc_b1  <= add_sat(acc_b1, delta_1_p0);
        acc_b2  <= add_sat(acc_b2, delta_2_p0);
      end
    end
  end

  // The layer inputs arrive with the sample, one cycle ahead of its delta,
  // so they are carried alongside delta in stage p0.
  logic signed [DATA_W-1:0] x_1_p0, x_2_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_1_p0 <= '0;
      x_2_p0 <= '0;
    end else if (accept) begin
      x_1_p0 <= x_1;
      x_2_p0 <= x_2;
    end
  end

  function automatic logic signed [DATA_W-1:0] x_1_hold_1();
    return x_1_p0;
  endfunction

  function automatic logic signed [DATA_W-1:0] x_2_hold_1();
    return x_2_p0;
  endfunction

  // ---- control: batch FSM and parameter update ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      update_valid  <= 1'b0;
      weight_11_new <= '0;
      weight_12_new <= '0;
      weight_21_new <= '0;
      weight_22_new <= '0;
      bias_1_new    <= '0;
      bias_2_new    <= '0;
    end else begin
      update_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept && in_last) state <= DRAIN;
        end
        // The last sample's accumulation lands at the end of this cycle.
        DRAIN: state <= UPDATE;
        UPDATE: begin
          state         <= IDLE;
          busy          <= 1'b0;
          update_valid  <= 1'b1;
          weight_11_new <= sub_sat(weight_11, mul_q(learning_rate, acc_w11));
          weight_12_new <= sub_sat(weight_12, mul_q(learning_rate, acc_w12));
          weight_21_new <= sub_sat(weight_21, mul_q(learning_rate, acc_w21));
          weight_22_new <= sub_sat(weight_22, mul_q(learning_rate, acc_w22));
          bias_1_new    <= sub_sat(bias_1, mul_q(learning_rate, acc_b1));
          bias_2_new    <= sub_sat(bias_2, mul_q(learning_rate, acc_b2));
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign delta_valid = vld_p0;
  assign delta_1     = delta_1_p0;
  assign delta_2     = delta_2_p0;
  assign grad_valid  = vld_p1;
  assign grad_in_1   = grad_in_1_p1;
  assign grad_in_2   = grad_in_2_p1;

endmodule

// File: tb/tb_layer1_backward.sv
module tb_layer1_backward;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last;
  logic signed [15:0] grad_1, grad_2, preact_1, preact_2, x_1, x_2;
  logic signed [15:0] weight_11, weight_12, weight_21, weight_22, bias_1, bias_2;
  logic signed [15:0] leak_factor, learning_rate;
  logic busy, delta_valid, grad_valid, update_valid;
  logic signed [15:0] delta_1, delta_2, grad_in_1, grad_in_2;
  logic signed [15:0] weight_11_new, weight_12_new, weight_21_new, weight_22_new;
  logic signed [15:0] bias_1_new, bias_2_new;

  layer1_backward dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .grad_1(grad_1), .grad_2(grad_2), .preact_1(preact_1), .preact_2(preact_2),
    .x_1(x_1), .x_2(x_2),
    .weight_11(weight_11), .weight_12(weight_12), .weight_21(weight_21), .weight_22(weight_22),
    .bias_1(bias_1), .bias_2(bias_2), .leak_factor(leak_factor), .learning_rate(learning_rate),
    .busy(busy), .delta_valid(delta_valid), .delta_1(delta_1), .delta_2(delta_2),
    .grad_valid(grad_valid), .grad_in_1(grad_in_1), .grad_in_2(grad_in_2),
    .update_valid(update_valid),
    .weight_11_new(weight_11_new), .weight_12_new(weight_12_new),
    .weight_21_new(weight_21_new), .weight_22_new(weight_22_new),
    .bias_1_new(bias_1_new), .bias_2_new(bias_2_new)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // batch description (sample arrays and parameters)
  int sg1[8], sg2[8], sp1[8], sp2[8], sx1[8], sx2[8];
  int pw[4], pb[2], pleak, plr;
  // model results
  int ed1[8], ed2[8], eg1[8], eg2[8], exp_new[6];
  int last_d1, last_d2, last_g1, last_g2;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Q8.8 product rounded toward minus infinity, then saturated
  function automatic int qmul(input int a, input int b);
    longint p, q;
    p = longint'(a) * longint'(b);
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return clamp(q);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic model(input int n);
    int aw[4];
    int ab[2];
    int d1, d2;
    aw = '{0, 0, 0, 0};
    ab = '{0, 0};
    for (int k = 0; k < n; k++) begin
      d1 = (sp1[k] > 0) ? sg1[k] : qmul(sg1[k], pleak);
      d2 = (sp2[k] > 0) ? sg2[k] : qmul(sg2[k], pleak);
      ed1[k] = d1;
      ed2[k] = d2;
      eg1[k] = clamp(qmul(pw[0], d1) + qmul(pw[1], d2));
      eg2[k] = clamp(qmul(pw[2], d1) + qmul(pw[3], d2));
      aw[0] = clamp(aw[0] + qmul(sx1[k], d1));
      aw[1] = clamp(aw[1] + qmul(sx1[k], d2));
      aw[2] = clamp(aw[2] + qmul(sx2[k], d1));
      aw[3] = clamp(aw[3] + qmul(sx2[k], d2));
      ab[0] = clamp(ab[0] + d1);
      ab[1] = clamp(ab[1] + d2);
    end
    for (int i = 0; i < 4; i++) exp_new[i] = clamp(pw[i] - qmul(plr, aw[i]));
    exp_new[4] = clamp(pb[0] - qmul(plr, ab[0]));
    exp_new[5] = clamp(pb[1] - qmul(plr, ab[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_params();
    weight_11 = 16'(pw[0]);
    weight_12 = 16'(pw[1]);
    weight_21 = 16'(pw[2]);
    weight_22 = 16'(pw[3]);
    bias_1 = 16'(pb[0]);
    bias_2 = 16'(pb[1]);
    leak_factor = 16'(pleak);
    learning_rate = 16'(plr);
  endtask

  task automatic drive_sample(input int k);
    grad_1 = 16'(sg1[k]);
    grad_2 = 16'(sg2[k]);
    preact_1 = 16'(sp1[k]);
    preact_2 = 16'(sp2[k]);
    x_1 = 16'(sx1[k]);
    x_2 = 16'(sx2[k]);
  endtask

  task automatic drive_noise();
    grad_1 = 16'($urandom);
    grad_2 = 16'($urandom);
    preact_1 = 16'($urandom);
    preact_2 = 16'($urandom);
    x_1 = 16'($urandom);
    x_2 = 16'($urandom);
  endtask

  task automatic check_new(input string nm);
    check({nm, "_w11_new"}, 32'(weight_11_new), exp_new[0]);
    check({nm, "_w12_new"}, 32'(weight_12_new), exp_new[1]);
    check({nm, "_w21_new"}, 32'(weight_21_new), exp_new[2]);
    check({nm, "_w22_new"}, 32'(weight_22_new), exp_new[3]);
    check({nm, "_b1_new"}, 32'(bias_1_new), exp_new[4]);
    check({nm, "_b2_new"}, 32'(bias_2_new), exp_new[5]);
  endtask

  // One batch of n samples, optional idle gap before sample gap_at (with a
  // stray in_last), optional start pulse in the second cycle, and in_valid
  // held high through DRAIN, UPDATE and the following IDLE cycle.
  task automatic run_batch(input int n, input int gap_at, input bit poke_start, input string nm);
    int sv[16];
    int sk[16];
    int ncyc;
    bit dv, gv;
    model(n);
    apply_params();
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_busy_start"}, 32'(busy), 1);
    ncyc = 0;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) begin
        sv[ncyc] = 0;
        sk[ncyc] = 0;
        ncyc++;
      end
      sv[ncyc] = 1;
      sk[ncyc] = k;
      ncyc++;
    end
    for (int c = 0; c < ncyc + 2; c++) begin
      if (c < ncyc && sv[c] == 1) begin
        drive_sample(sk[c]);
        in_valid = 1'b1;
        in_last = (sk[c] == n - 1);
      end else begin
        drive_noise();
        in_valid = (c >= ncyc);
        in_last = 1'b1;
      end
      start = poke_start && (c == 1);
      tick();
      start = 1'b0;
      dv = (c < ncyc) && (sv[c] == 1);
      gv = (c >= 1) && (c - 1 < ncyc) && (sv[c-1] == 1);
      check({nm, "_delta_valid"}, 32'(delta_valid), int'(dv));
      if (dv) begin
        last_d1 = ed1[sk[c]];
        last_d2 = ed2[sk[c]];
      end
      check({nm, "_delta_1"}, 32'(delta_1), last_d1);
      check({nm, "_delta_2"}, 32'(delta_2), last_d2);
      check({nm, "_grad_valid"}, 32'(grad_valid), int'(gv));
      if (gv) begin
        last_g1 = eg1[sk[c-1]];
        last_g2 = eg2[sk[c-1]];
      end
      check({nm, "_grad_in_1"}, 32'(grad_in_1), last_g1);
      check({nm, "_grad_in_2"}, 32'(grad_in_2), last_g2);
      check({nm, "_update_valid"}, 32'(update_valid), int'(c == ncyc + 1));
      check({nm, "_busy"}, 32'(busy), int'(c != ncyc + 1));
    end
    check_new(nm);
    // in_valid still high, now in IDLE: must be ignored
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    check({nm, "_idle_delta_valid"}, 32'(delta_valid), 0);
    check({nm, "_idle_grad_valid"}, 32'(grad_valid), 0);
    check({nm, "_idle_update_valid"}, 32'(update_valid), 0);
    check({nm, "_idle_busy"}, 32'(busy), 0);
    check({nm, "_idle_delta_1_hold"}, 32'(delta_1), last_d1);
    check_new({nm, "_hold"});
  endtask

  task automatic setup_s1();
    pw = '{256, 0, 0, 256};
    pb = '{0, 0};
    pleak = 32;
    plr = 256;
    sg1[0] = 256; sg2[0] = 256;
    sp1[0] = 512; sp2[0] = -256;
    sx1[0] = 256; sx2[0] = 512;
  endtask

  task automatic check_s1_literal(input string nm);
    check({nm, "_delta_1"}, 32'(delta_1), 256);
    check({nm, "_delta_2"}, 32'(delta_2), 32);
    check({nm, "_grad_in_1"}, 32'(grad_in_1), 256);
    check({nm, "_grad_in_2"}, 32'(grad_in_2), 32);
    check({nm, "_w11"}, 32'(weight_11_new), 0);
    check({nm, "_w12"}, 32'(weight_12_new), -32);
    check({nm, "_w21"}, 32'(weight_21_new), -512);
    check({nm, "_w22"}, 32'(weight_22_new), 192);
    check({nm, "_b1"}, 32'(bias_1_new), -256);
    check({nm, "_b2"}, 32'(bias_2_new), -32);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"}, 32'(busy), 0);
    check({nm, "_delta_valid"}, 32'(delta_valid), 0);
    check({nm, "_grad_valid"}, 32'(grad_valid), 0);
    check({nm, "_update_valid"}, 32'(update_valid), 0);
    check({nm, "_delta_1"}, 32'(delta_1), 0);
    check({nm, "_delta_2"}, 32'(delta_2), 0);
    check({nm, "_grad_in_1"}, 32'(grad_in_1), 0);
    check({nm, "_grad_in_2"}, 32'(grad_in_2), 0);
    check({nm, "_w11_new"}, 32'(weight_11_new), 0);
    check({nm, "_w12_new"}, 32'(weight_12_new), 0);
    check({nm, "_w21_new"}, 32'(weight_21_new), 0);
    check({nm, "_w22_new"}, 32'(weight_22_new), 0);
    check({nm, "_b1_new"}, 32'(bias_1_new), 0);
    check({nm, "_b2_new"}, 32'(bias_2_new), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, g;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    drive_noise();
    pw = '{0, 0, 0, 0};
    pb = '{0, 0};
    pleak = 0;
    plr = 0;
    apply_params();
    last_d1 = 0; last_d2 = 0; last_g1 = 0; last_g2 = 0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // single-sample batch from the test plan
    setup_s1();
    run_batch(1, -1, 1'b0, "s1");
    check_s1_literal("s1_lit");

    // zero pre-activation takes the leak path
    setup_s1();
    sg1[0] = 256; sg2[0] = -512;
    sp1[0] = 0;   sp2[0] = 0;
    run_batch(1, -1, 1'b0, "leak0");
    check("leak0_lit_d1", 32'(delta_1), 32);
    check("leak0_lit_d2", 32'(delta_2), -64);

    // saturation across two samples
    pw = '{-32768, 0, 0, 0};
    pb = '{0, 0};
    pleak = 32;
    plr = 256;
    for (int k = 0; k < 2; k++) begin
      sg1[k] = 32767; sp1[k] = 256; sx1[k] = 32767;
      sg2[k] = 0;     sp2[k] = 256; sx2[k] = 0;
    end
    run_batch(2, -1, 1'b0, "sat");
    check("sat_lit_w11", 32'(weight_11_new), -32768);

    // three back-to-back samples, start pulsed mid-ACCUM
    pw = '{0, 0, 0, 0};
    pb = '{0, 0};
    pleak = 32;
    plr = 128;
    for (int k = 0; k < 3; k++) begin
      sg1[k] = 256; sg2[k] = 0;
      sp1[k] = 256; sp2[k] = 256;
      sx1[k] = 256; sx2[k] = 256;
    end
    run_batch(3, -1, 1'b1, "b2b");
    check("b2b_lit_b1", 32'(bias_1_new), -384);
    check("b2b_lit_w11", 32'(weight_11_new), -384);
    check("b2b_lit_w21", 32'(weight_21_new), -384);

    // reset in the middle of a four-sample batch
    setup_s1();
    for (int k = 1; k < 4; k++) begin
      sg1[k] = rnd16(); sg2[k] = rnd16();
      sp1[k] = rnd16(); sp2[k] = rnd16();
      sx1[k] = rnd16(); sx2[k] = rnd16();
    end
    apply_params();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_sample(k);
      in_valid = 1'b1;
      in_last = 1'b0;
      tick();
    end
    drive_sample(2);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    rst = 1'b0;
    last_d1 = 0; last_d2 = 0; last_g1 = 0; last_g2 = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_after_update_valid", 32'(update_valid), 0);
      check("rst_after_delta_valid", 32'(delta_valid), 0);
      check("rst_after_grad_valid", 32'(grad_valid), 0);
      check("rst_after_busy", 32'(busy), 0);
    end
    setup_s1();
    run_batch(1, -1, 1'b0, "s1_again");
    check_s1_literal("s1_again_lit");

    // randomized batches against the model
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 5);
      g = $urandom_range(0, n);
      for (int i = 0; i < 4; i++) pw[i] = rnd16();
      pb[0] = rnd16();
      pb[1] = rnd16();
      pleak = $urandom_range(0, 511);
      plr = rnd16();
      for (int k = 0; k < n; k++) begin
        sg1[k] = rnd16(); sg2[k] = rnd16();
        sp1[k] = rnd16(); sp2[k] = rnd16();
        sx1[k] = rnd16(); sx2[k] = rnd16();
      end
      run_batch(n, g, b[0], $sformatf("rnd%0d", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer1_backward.md
# layer1_backward

Backward-pass counterpart of the first dense layer (2x2 systolic matmul, per-neuron bias, leaky ReLU). For a batch of streamed samples it applies the leaky-ReLU derivative to the upstream gradients and propagates input gradients to the previous stage. It also accumulates weight and bias gradients over the batch, then issues one SGD update of the six layer parameters. All values are signed Q8.8 in 16 bits.

## Interface
Parameters: none. Q8.8 is fixed, so 1.0 = 256.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a batch (honoured in IDLE only)
- in_valid  in  1  sample strobe (accepted in ACCUM only)
- in_last  in  1  qualifies in_valid; final sample of the batch
- grad_1, grad_2  in  16  dL/dout1, dL/dout2
- preact_1, preact_2  in  16  forward pre-activation (post-bias) values for this sample
- x_1, x_2  in  16  forward layer inputs for this sample
- weight_11, weight_12, weight_21, weight_22  in  16  current weights; must be held stable from start until update_valid
- bias_1, bias_2  in  16  current biases; same stability rule as the weights
- leak_factor  in  16  leaky-ReLU negative slope
- learning_rate  in  16  SGD step size
- busy  out  1  high in any state except IDLE
- delta_valid  out  1  delta_1/delta_2 are valid
- delta_1, delta_2  out  16  local gradients after the activation derivative
- grad_valid  out  1  grad_in_1/grad_in_2 are valid
- grad_in_1, grad_in_2  out  16  dL/dx for the previous layer
- update_valid  out  1  one-cycle pulse; new parameters are valid
- weight_11_new, weight_12_new, weight_21_new, weight_22_new, bias_1_new, bias_2_new  out  16  updated parameters, held until the next update

## Operation
- Forward convention: out1 = x_1·w11 + x_2·w21 + b1 and out2 = x_1·w12 + x_2·w22 + b2.
- Multiplication: full 32-bit signed product, arithmetic shift right by 8 (floor), then saturate to [-32768, 32767]. Every add and subtract also saturates.
- Stage 1 (activation derivative):
  - delta_j = grad_j when preact_j > 0.
  - delta_j = mul(grad_j, leak_factor) when preact_j ≤ 0; preact = 0 takes the leak path.
- Stage 2 (propagation):
  - grad_in_1 = mul(w11, delta_1) + mul(w12, delta_2).
  - grad_in_2 = mul(w21, delta_1) + mul(w22, delta_2).
- Stage 2 (accumulation, six 16-bit saturating accumulators):
  - acc_w_ij += mul(x_i, delta_j).
  - acc_b_j += delta_j.
- Update: p_new = p − mul(learning_rate, acc_p), applied to all six parameters.
- FSM states: IDLE, ACCUM, DRAIN, UPDATE.
  - IDLE → ACCUM on start; all accumulators clear on this edge.
  - ACCUM → DRAIN on an accepted sample with in_last high.
  - DRAIN → UPDATE after one cycle, once the last sample has been accumulated.
  - UPDATE → IDLE after one cycle; the *_new registers load and update_valid is asserted.
- Ignored inputs:
  - start outside IDLE.
  - in_valid outside ACCUM, including in IDLE, DRAIN and UPDATE. Samples in those states do not enter the pipeline.
- in_last without in_valid is ignored.
- Back-to-back samples (in_valid every cycle) are supported at full rate.
- Accumulators keep their value after an update until the next start.

## Timing
- Sample accepted in cycle T:
  - delta_valid is high in T+1.
  - grad_valid is high in T+2, and its accumulation is complete at the end of T+1.
- Last sample in cycle T:
  - DRAIN in T+1.
  - UPDATE in T+2.
  - update_valid is high in T+3, with state IDLE and busy low in T+3.
- A new start is accepted in T+3.
- delta_valid and grad_valid are single-cycle per sample; data outputs hold their last value when not valid.
- Reset, asynchronous at any time including mid-batch:
  - State goes to IDLE; all outputs and accumulators go to 0.
  - In-flight pipeline stages are cleared, so no valid strobe follows reset.

## Test plan
- Single-sample batch: weights (w11, w12, w21, w22) = (256, 0, 0, 256), biases 0, leak 32, lr 256, grad = (256, 256), preact = (512, −256), x = (256, 512), in_last = 1. Required response:
  - delta = (256, 32).
  - grad_in = (256, 32).
  - new (w11, w12, w21, w22, b1, b2) = (0, −32, −512, 192, −256, −32).
  - update_valid exactly 3 cycles after the sample.
- preact = (0, 0), grad = (256, −512), leak 32 → delta = (32, −64).
- Saturation, two samples: grad_1 = 32767, preact_1 = 256, x_1 = 32767, w11 = −32768, lr 256 → acc_w11 = 32767 and weight_11_new = −32768 (no wrap).
- Three back-to-back samples with grad = (256, 0) each, x = (256, 256), preact positive, plus protocol checks. Required response:
  - acc_b1 = 768; with lr 128 and all parameters 0, b1_new = −384 and w11_new = w21_new = −384.
  - start pulsed mid-ACCUM is ignored.
  - in_valid pulsed in IDLE produces no delta_valid.
- Reset mid-batch: assert rst after 2 of 4 samples. Required response:
  - All outputs 0 and busy low.
  - No update_valid follows reset.
  - A fresh one-sample batch then yields results identical to the first scenario.
